muldiv_unit: RTL

Parametrised iterative multiply/divide unit with architectural HI/LO registers, replacing the fixed 32-bit unsigned multiplier and separate HiLo pair in the EX stage. It supports signed and unsigned multiply and divide (MULT/MULTU/DIV/DIVU), MTHI/MTLO writes and an abort for pipeline flush. It exposes a start/busy/done handshake so the hazard logic can stall dependent MFHI/MFLO instructions.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_step.sv | 27 ++
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  // op[0] selects signed, op[1] selects divide
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, b_i} : '0);
    // Partial remainder with the next dividend bit shifted in, minus divisor
    diff = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, b_i};
    if (!is_div_i) begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end else begin
      acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide with architectural HI/LO registers.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod;
  logic [WIDTH-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
  logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d;
  logic               dz_q, dz_d, dzf_q, dzf_d, busy_q;
  logic               sgn_a, sgn_b, dz_new;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (div_q),
    .acc_i    (acc_q),
    .b_i      (b_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    dzf_d   = dzf_q;

    sgn_a  = op_is_signed(op) & op_a[WIDTH-1];
    sgn_b  = op_is_signed(op) & op_b[WIDTH-1];
    dz_new = op_is_div(op) & (op_b == '0);
    // Divide by zero keeps the raw dividend so the remainder path returns op_a untouched
    mag_a  = (sgn_a && !dz_new) ? -op_a : op_a;
    mag_b  = sgn_b ? -op_b : op_b;
    prod   = neg_q ? -acc_q : acc_q;
    quo    = acc_q[WIDTH-1:0];
    rem    = acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !abort) begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(WIDTH);
          acc_d   = {{WIDTH{1'b0}}, mag_a};
          b_d     = mag_b;
          div_d   = op_is_div(op);
          neg_d   = (sgn_a ^ sgn_b) & ~dz_new;
          rneg_d  = sgn_a & op_is_div(op) & ~dz_new;
          dz_d    = dz_new;
          dzf_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!abort) begin
          if (div_q) begin
            lo_d = dz_q ? '1 : (neg_q ? -quo : quo);
            hi_d = rneg_q ? -rem : rem;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
          dzf_d = dz_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      dzf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      dzf_q   <= dzf_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign busy     = busy_q;
  assign done     = (state_q == S_FIX) && !abort;
  assign div_zero = dzf_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
